// File: rtl/matrix_engine_pkg.sv
// matrix_engine_pkg: shared definitions for the matrix coprocessor.
//   - FSM state encoding
//   - header opcodes (MUL / ADD / HADAMARD)
//   - mem_operation encodings
//   - header word offsets and the base address of matrix A
package matrix_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_LD_A,
    ST_LD_B,
    ST_EXEC,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_HAD = 2'd2;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam int HDR_WA = 0;
  localparam int HDR_HA = 1;
  localparam int HDR_WB = 2;
  localparam int HDR_HB = 3;
  localparam int HDR_OP = 4;

  localparam int A_BASE = 5;

endpackage

// File: rtl/matrix_engine_alu.sv
// matrix_engine_alu: element arithmetic for the matrix coprocessor.
// Holds the wide signed accumulator and reduces it to a DATA_W result.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clr_i        zero the accumulator (start of a new C element)
//   en_i         apply op_i to operands a_i/b_i this cycle
//   op_i         OP_MUL accumulates a*b, OP_ADD loads a+b, OP_HAD loads a*b
//   a_i, b_i     signed DATA_W operands
//   res_o        accumulator reduced to DATA_W
// Build option: MATRIX_ENGINE_SATURATE_EN makes res_o saturate instead of wrap.
module matrix_engine_alu
  import matrix_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W+8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [1:0]               op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [ACC_W-1:0] a_ext, b_ext, prod, acc_q, acc_d;

  function automatic logic signed [DATA_W-1:0] fit(input logic signed [ACC_W-1:0] v);
`ifdef MATRIX_ENGINE_SATURATE_EN
    logic [ACC_W-DATA_W:0] hi;
    hi = v[ACC_W-1:DATA_W-1];
    // Value fits when every bit above the result sign matches it.
    if ((&hi) || !(|hi)) fit = v[DATA_W-1:0];
    else if (v[ACC_W-1]) fit = {1'b1, {(DATA_W-1){1'b0}}};
    else                 fit = {1'b0, {(DATA_W-1){1'b1}}};
`else
    fit = v[DATA_W-1:0];
`endif
  endfunction

  assign a_ext = {{(ACC_W-DATA_W){a_i[DATA_W-1]}}, a_i};
  assign b_ext = {{(ACC_W-DATA_W){b_i[DATA_W-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      case (op_i)
        OP_MUL:  acc_d = acc_q + prod;
        OP_ADD:  acc_d = a_ext + b_ext;
        default: acc_d = prod;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign res_o = fit(acc_q);

endmodule

// File: rtl/matrix_engine.sv
// matrix_engine: memory-mapped matrix coprocessor (MUL / ADD / HADAMARD).
// Reads a five-word header at address 0, then streams A and B elements and
// writes each C element through a single-port request/done handshake.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   enable          rising edge starts a job (from IDLE or DONE only)
//   mem_opdone      current access completed (read data valid / write taken)
//   data_i          read data
//   data_o          write data
//   addr_o          access address
//   mem_operation   00 none, 01 read, 11 write
//   done, error     job finished / job rejected for an illegal header
// Build option: MATRIX_ENGINE_SATURATE_EN (saturating result, see alu).
module matrix_engine
  import matrix_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 2*DATA_W+8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;
  logic en_prev_q;
  logic issued_q, issued_d;
  logic [1:0] op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic done_q, done_d, error_q, error_d;
  logic [2:0] hdr_idx_q, hdr_idx_d;
  logic [ADDR_W-1:0] wa_q, wa_d, ha_q, ha_d, wb_q, wb_d, hb_q, hb_d;
  logic [1:0] opc_q, opc_d;
  logic opc_bad_q, opc_bad_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d, c_base_q, c_base_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d;

  logic start, is_mul, legal, empty, alu_clr, alu_en;
  logic [ADDR_W-1:0] dim_v, wc, a_addr, b_addr, c_addr;
  logic signed [DATA_W-1:0] alu_res;

  assign start  = enable & ~en_prev_q;
  assign is_mul = (opc_q == OP_MUL);
  assign dim_v  = ADDR_W'(data_i);
  assign wc     = is_mul ? wb_q : wa_q;
  assign legal  = !opc_bad_q && (is_mul ? (wa_q == hb_q) : (wa_q == wb_q && ha_q == hb_q));
  assign empty  = (wa_q == '0) || (ha_q == '0) || (wb_q == '0) || (hb_q == '0);

  // Address products wrap modulo 2^ADDR_W.
  assign a_addr = ADDR_W'(A_BASE) + i_q * wa_q + (is_mul ? k_q : j_q);
  assign b_addr = is_mul ? (b_base_q + k_q * wb_q + j_q) : (b_base_q + i_q * wb_q + j_q);
  assign c_addr = c_base_q + i_q * wc + j_q;

  matrix_engine_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_alu (
    .clk   (clk),
    .reset (reset),
    .clr_i (alu_clr),
    .en_i  (alu_en),
    .op_i  (opc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  // Each access state spends its first cycle idle on the bus, issues at the
  // end of it, then waits with outputs frozen until mem_opdone is sampled.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    error_d   = error_q;
    hdr_idx_d = hdr_idx_q;
    wa_d = wa_q; ha_d = ha_q; wb_d = wb_q; hb_d = hb_q;
    opc_d     = opc_q;
    opc_bad_d = opc_bad_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    i_d = i_q; j_d = j_q; k_d = k_q;
    a_d = a_q; b_d = b_q;
    alu_clr = 1'b0;
    alu_en  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) done_d = 1'b1;
        if (start) begin
          state_d   = ST_HDR;
          done_d    = 1'b0;
          error_d   = 1'b0;
          hdr_idx_d = '0;
        end
      end
      ST_HDR: begin
        if (!issued_q) begin
          op_d     = MEM_READ;
          addr_d   = ADDR_W'(hdr_idx_q);
          issued_d = 1'b1;
        end else if (mem_opdone) begin
          op_d     = MEM_NONE;
          issued_d = 1'b0;
          case (hdr_idx_q)
            3'(HDR_WA): wa_d = dim_v;
            3'(HDR_HA): ha_d = dim_v;
            3'(HDR_WB): wb_d = dim_v;
            3'(HDR_HB): hb_d = dim_v;
            default: begin
              opc_d     = data_i[1:0];
              opc_bad_d = (data_i > DATA_W'(OP_HAD));
            end
          endcase
          if (hdr_idx_q == 3'(HDR_OP)) state_d = ST_CHECK;
          else                         hdr_idx_d = hdr_idx_q + 3'd1;
        end
      end
      ST_CHECK: begin
        b_base_d = ADDR_W'(A_BASE) + ha_q * wa_q;
        c_base_d = b_base_d + hb_q * wb_q;
        i_d = '0; j_d = '0; k_d = '0;
        alu_clr = 1'b1;
        error_d = !legal;
        state_d = (!legal || empty) ? ST_DONE : ST_LD_A;
      end
      ST_LD_A: begin
        if (!issued_q) begin
          op_d     = MEM_READ;
          addr_d   = a_addr;
          issued_d = 1'b1;
        end else if (mem_opdone) begin
          op_d     = MEM_NONE;
          issued_d = 1'b0;
          a_d      = $signed(data_i);
          state_d  = ST_LD_B;
        end
      end
      ST_LD_B: begin
        if (!issued_q) begin
          op_d     = MEM_READ;
          addr_d   = b_addr;
          issued_d = 1'b1;
        end else if (mem_opdone) begin
          op_d     = MEM_NONE;
          issued_d = 1'b0;
          b_d      = $signed(data_i);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (is_mul && (k_q != wa_q - ADDR_W'(1))) begin
          k_d     = k_q + ADDR_W'(1);
          state_d = ST_LD_A;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (!issued_q) begin
          op_d     = MEM_WRITE;
          addr_d   = c_addr;
          wdata_d  = alu_res;
          issued_d = 1'b1;
        end else if (mem_opdone) begin
          op_d     = MEM_NONE;
          issued_d = 1'b0;
          k_d      = '0;
          alu_clr  = 1'b1;
          state_d  = ST_LD_A;
          if (j_q == wc - ADDR_W'(1)) begin
            j_d = '0;
            if (i_q == ha_q - ADDR_W'(1)) state_d = ST_DONE;
            else                          i_d = i_q + ADDR_W'(1);
          end else begin
            j_d = j_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_prev_q <= 1'b0;
      issued_q  <= 1'b0;
      op_q      <= MEM_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hdr_idx_q <= '0;
      wa_q <= '0; ha_q <= '0; wb_q <= '0; hb_q <= '0;
      opc_q     <= OP_MUL;
      opc_bad_q <= 1'b0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      i_q <= '0; j_q <= '0; k_q <= '0;
      a_q <= '0; b_q <= '0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= enable;
      issued_q  <= issued_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hdr_idx_q <= hdr_idx_d;
      wa_q <= wa_d; ha_q <= ha_d; wb_q <= wb_d; hb_q <= hb_d;
      opc_q     <= opc_d;
      opc_bad_q <= opc_bad_d;
      b_base_q  <= b_base_d;
      c_base_q  <= c_base_d;
      i_q <= i_d; j_q <= j_d; k_q <= k_d;
      a_q <= a_d; b_q <= b_d;
    end
  end

  assign mem_operation = op_q;
  assign addr_o        = addr_q;
  assign data_o        = wdata_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_matrix_engine.sv
// tb_matrix_engine: directed-vector bench with a write scoreboard and a
// memory model that also watches the access handshake.
module tb_matrix_engine;

  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset, enable, mem_opdone;
  logic [DW-1:0] data_i, data_o;
  logic [AW-1:0] addr_o;
  logic [1:0] mem_operation;
  logic done, error;

  matrix_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mem_opdone    (mem_opdone),
    .data_i        (data_i),
    .data_o        (data_o),
    .addr_o        (addr_o),
    .mem_operation (mem_operation),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] mem [0:63];
  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_acc = 0;
  bit rand_dly = 0;

  // Memory model, write scoreboard and handshake monitor (negedge).
  bit pend = 0;
  int wcnt = 0;
  logic [1:0] prev_op = 2'b00;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic prev_done = 1'b0;
  logic rst_prev = 1'b1;
  exp_t e;

  always @(negedge clk) begin
    if (!(reset || rst_prev) && prev_op != 2'b00) begin
      checks++;
      if (!prev_done) begin
        if (mem_operation !== prev_op || addr_o !== prev_addr ||
            (prev_op == 2'b11 && data_o !== prev_data)) begin
          errors++;
          $display("FAIL hold: op %b addr %0d data %0h, required op %b addr %0d data %0h",
                   mem_operation, addr_o, data_o, prev_op, prev_addr, prev_data);
        end
      end else if (mem_operation !== 2'b00) begin
        errors++;
        $display("FAIL gap: op %b after completed access, required 00", mem_operation);
      end
    end
    if (mem_operation == 2'b00 || reset) begin
      pend = 0;
      mem_opdone = 1'b0;
    end else begin
      if (!pend) begin
        pend = 1;
        n_acc++;
        wcnt = rand_dly ? int'($urandom_range(0, 3)) : 0;
      end
      if (wcnt == 0) begin
        mem_opdone = 1'b1;
        if (mem_operation == 2'b01) begin
          data_i = mem[addr_o[5:0]];
        end else begin
          n_wr++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected write addr %0d data %0h", addr_o, data_o);
          end else begin
            e = exp_q.pop_front();
            if (addr_o !== e.a || data_o !== e.d) begin
              errors++;
              $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                       addr_o, data_o, e.a, e.d);
            end
          end
          mem[addr_o[5:0]] = data_o;
        end
      end else begin
        wcnt--;
        mem_opdone = 1'b0;
      end
    end
    prev_op   = mem_operation;
    prev_addr = addr_o;
    prev_data = data_o;
    prev_done = mem_opdone;
    rst_prev  = reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input int a, input logic [DW-1:0] d);
    exp_t x;
    x.a = AW'(a);
    x.d = d;
    exp_q.push_back(x);
  endtask

  task automatic set_hdr(input int wa, input int ha, input int wb, input int hb, input int op);
    mem[0] = DW'(wa); mem[1] = DW'(ha); mem[2] = DW'(wb); mem[3] = DW'(hb); mem[4] = DW'(op);
  endtask

  task automatic set_ab(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    mem[5] = a0; mem[6] = a1; mem[7] = a2; mem[8] = a3;
    mem[9] = b0; mem[10] = b1; mem[11] = b2; mem[12] = b3;
  endtask

  task automatic run(input string name, input logic exp_err, input int exp_writes, input bit hold);
    int w0;
    int c;
    w0 = n_wr;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 if (!hold) enable = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 3000) begin
      errors++;
      $display("FAIL %s timeout: done %b required 1", name, done);
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " error"}, 32'(error), 32'(exp_err));
    chk({name, " writes"}, 32'(n_wr - w0), 32'(exp_writes));
    chk({name, " pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int a0;
    int c;
    reset = 1'b1; enable = 1'b0; mem_opdone = 1'b0; data_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst op", 32'(mem_operation), 32'd0);
    chk("rst addr", 32'(addr_o), 32'd0);
    chk("rst data", 32'(data_o), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    reset = 1'b0;

    set_hdr(2, 2, 2, 2, 0);
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    push(13, 19); push(14, 22); push(15, 43); push(16, 50);
    run("mul", 1'b0, 4, 0);

    set_hdr(2, 2, 2, 2, 1);
    push(13, 6); push(14, 8); push(15, 10); push(16, 12);
    run("add", 1'b0, 4, 0);

    set_hdr(2, 2, 2, 2, 2);
    push(13, 5); push(14, 12); push(15, 21); push(16, 32);
    run("had", 1'b0, 4, 0);

    rand_dly = 1;
    set_hdr(2, 2, 2, 2, 0);
    set_ab(8'(-1), 2, 3, 8'(-4), 5, 6, 7, 8);
    push(13, 9); push(14, 10); push(15, 8'(-13)); push(16, 8'(-14));
    run("mul_dly", 1'b0, 4, 0);
    rand_dly = 0;

    set_hdr(3, 2, 2, 2, 0);
    run("mul_bad_dim", 1'b1, 0, 0);
    set_hdr(2, 2, 2, 2, 5);
    run("bad_op", 1'b1, 0, 0);

    a0 = n_acc;
    set_hdr(0, 2, 0, 2, 1);
    run("empty", 1'b0, 0, 0);
    chk("empty accesses", 32'(n_acc - a0), 32'd5);

    set_hdr(1, 1, 1, 1, 0);
    mem[5] = 8'd100; mem[6] = 8'd100;
`ifdef MATRIX_ENGINE_SATURATE_EN
    push(7, 8'h7F);
`else
    push(7, 8'h10);
`endif
    run("sat_pos", 1'b0, 1, 0);
    mem[5] = 8'h9C;
`ifdef MATRIX_ENGINE_SATURATE_EN
    push(7, 8'h80);
`else
    push(7, 8'hF0);
`endif
    run("sat_neg", 1'b0, 1, 0);

    // Reset while the first B operand read is outstanding.
    set_hdr(2, 2, 2, 2, 0);
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    c = 0;
    while (!(mem_operation == 2'b01 && addr_o == AW'(9)) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("ldb reached", 32'(c < 500), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid op", 32'(mem_operation), 32'd0);
    chk("mid addr", 32'(addr_o), 32'd0);
    chk("mid data", 32'(data_o), 32'd0);
    chk("mid done", 32'(done), 32'd0);
    chk("mid error", 32'(error), 32'd0);

    push(13, 19); push(14, 22); push(15, 43); push(16, 50);
    run("after_rst", 1'b0, 4, 1);
    a0 = n_acc;
    repeat (40) @(posedge clk);
    #1;
    chk("held enable accesses", 32'(n_acc - a0), 32'd0);
    chk("held enable done", 32'(done), 32'd1);
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/matrix_engine.md
# matrix_engine

Parametrised successor to the single-mode matrix multiplier: a memory-mapped matrix coprocessor that reads a five-word header, then A and B, and writes C through the shared single-port memory handshake (`mem_operation` / `mem_opdone`). It supports three operations, MUL, ADD and HADAMARD, selected by a header opcode. Data and address widths are configurable, accumulation is wide and signed, and illegal dimension combinations raise an error flag. It sits beside the other KnightMCU accelerators as a memory-bus master started by `enable`.

## Interface
- `DATA_W`, 32: element width, signed two's complement.
- `ADDR_W`, 32: memory address width.
- `ACC_W`, 2*DATA_W+8: accumulator width; must be ≥ 2*DATA_W.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock, and reset is synchronous and active-high.
- `enable` in 1: start request; a 0→1 transition sampled on `clk` starts a job.
- `mem_opdone` in 1: memory has completed the current access (read data valid / write accepted).
- `data_i` in DATA_W: read data.
- `data_o` out DATA_W: write data.
- `addr_o` out ADDR_W: access address.
- `mem_operation` out 2: 00 none, 01 read, 11 write; 10 is never driven.
- `done` out 1: job finished; held until the next start.
- `error` out 1: job aborted for illegal header; valid while `done`=1.

## Operation
- Header words at addresses 0..4: width_a, height_a, width_b, height_b, opcode. Opcodes: 0 MUL (C=A·B), 1 ADD (C=A+B), 2 HADAMARD (C=A∘B). All others are illegal.
- Memory layout, row-major, one element per address:
  - A_base = 5
  - B_base = A_base + ha·wa
  - C_base = B_base + hb·wb
- C dimensions: ha×wb for MUL, ha×wa for ADD and HADAMARD.
- Legality: MUL requires wa==hb. ADD and HADAMARD require wa==wb and ha==hb. Illegal → no C writes, `done`=1, `error`=1.
- Any zero dimension on a legal header: no A/B/C accesses, `done`=1, `error`=0.
- States and transitions:
  - IDLE → HDR on the enable rising edge.
  - HDR (5 reads) → CHECK.
  - CHECK → LD_A, or → DONE when the job is empty or illegal.
  - LD_A → LD_B → EXEC.
  - EXEC loops to LD_A while k < wa−1 in MUL. In ADD and HADAMARD, and on the last k, EXEC → WR.
  - WR advances (i,j) and goes to LD_A, or → DONE after the last element.
  - DONE → HDR on the next enable rising edge.
- Arithmetic:
  - MUL: acc += sext(a)·sext(b) in ACC_W; acc clears on entry to each element.
  - ADD: acc = sext(a)+sext(b).
  - HADAMARD: acc = a·b.
  - Result is the low DATA_W bits of acc (see Configuration).
- Address products are computed in ADDR_W and wrap modulo 2^ADDR_W. Overflow is not detected.
- `enable` edges while busy (not IDLE/DONE) are ignored. Holding `enable` high does not retrigger.

## Timing
- Reset values: `mem_operation`=00, `addr_o`=0, `data_o`=0, `done`=0, `error`=0. State = IDLE; all dimension, index and accumulator registers = 0.
- Access handshake:
  - The block drives `addr_o` and `mem_operation` (and `data_o` for writes) in a cycle, then holds them stable until `mem_opdone` is sampled high.
  - On that edge, read data is captured and `mem_operation` returns to 00.
  - At least one 00 cycle separates consecutive accesses.
- Cycle counts with zero-wait memory (`mem_opdone` high in the first cycle of the access):
  - Each access takes 2 cycles (issue + idle).
  - EXEC takes 1 cycle.
  - A MUL element takes wa·5 + 2 cycles.
- `done` rises 1 cycle after entering DONE and clears on the cycle HDR is entered.
- `reset` mid-job has priority over everything: all outputs take reset values on the next edge, and the partial C is not completed.

## Configuration
- `MATRIX_ENGINE_SATURATE_EN` defined: the result written to C saturates acc to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Undefined: the result is acc truncated to the low DATA_W bits (wrap).

## Structure
- `matrix_engine_pkg` holds:
  - state enum;
  - opcode constants (OP_MUL/OP_ADD/OP_HAD);
  - `mem_operation` encodings (MEM_NONE/MEM_READ/MEM_WRITE);
  - header word offsets and A_base.
- Sub-module `matrix_engine_alu` contains the combinational multiply/add, accumulator register and saturation logic; the FSM and address generation stay in `matrix_engine`.

## Test plan
- MUL 2×2, A=[1 2;3 4] at 5..8, B=[5 6;7 8] at 9..12 → C at 13..16 = 19, 22, 43, 50; `done`=1, `error`=0.
- ADD 2×2, same operands → C at 13..16 = 6, 8, 10, 12; HADAMARD → 5, 12, 21, 32.
- MUL with wa=3, hb=2 → zero writes, `done`=1, `error`=1; opcode 5 → same result.
- DATA_W=8, 1×1 MUL 100·100 → C = 127 with the macro, 16 (0x10) without; −100·100 → −128 with the macro.
- Random 0–3-cycle `mem_opdone` delays → `addr_o`/`data_o` stable during each access, and a 00 gap between accesses.
- `reset` asserted during LD_B → next cycle all outputs 0. A later `enable` pulse runs a full job correctly. `enable` held high after `done` → no second job.
